// File: rtl/serial_twos_comp_n.sv
// Multi-channel LSB-first serial unit: pass, two's-complement negate or one's complement per frame.
// All outputs are registered, with one cycle of latency from each processed input beat.
module serial_twos_comp_n #(
    parameter int W  = 8,
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic [1:0]    mode,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] dout,
    output logic          out_valid,
    output logic          out_first,
    output logic          out_last,
    output logic [CH-1:0] ovf,
    output logic          abort
);
    localparam int CW = $clog2(W);
    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_RUN    = 1'b1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CH-1:0] r_seen;
    logic [1:0]    r_mode;
    logic [CH-1:0] r_dout;
    logic [CH-1:0] r_ovf;
    logic          r_valid;
    logic          r_first;
    logic          r_last;
    logic          r_abort;

    logic          w_start;
    logic          w_proc;
    logic [1:0]    w_mode;
    logic [CH-1:0] w_seen;
    logic [CW-1:0] w_idx;
    logic          w_last;
    logic          w_neg;
    logic          w_inv;
    logic [CH-1:0] w_bits;
    logic [CH-1:0] w_ovf;

    // An in_first beat always begins a fresh frame, so seen/mode/index come from the beat itself.
    assign w_start = in_valid & in_first;
    assign w_proc  = in_valid & (in_first | (r_state == S_RUN));
    assign w_mode  = w_start ? mode : r_mode;
    assign w_seen  = w_start ? '0 : r_seen;
    assign w_idx   = w_start ? '0 : r_cnt;
    assign w_last  = (w_idx == LAST_IDX);
    assign w_neg   = (w_mode == 2'b01);
    assign w_inv   = (w_mode == 2'b10);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            assign w_bits[gi] = w_neg ? (din[gi] ^ w_seen[gi]) :
                                w_inv ? ~din[gi] : din[gi];
            // Only -2^(W-1) reaches the sign bit with no earlier 1 and a 1 on top.
            assign w_ovf[gi]  = w_neg & w_last & din[gi] & ~w_seen[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_seen  <= '0;
            r_mode  <= 2'b00;
            r_dout  <= '0;
            r_ovf   <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_valid <= w_proc;
            r_first <= w_proc & (w_idx == '0);
            r_last  <= w_proc & w_last;
            r_abort <= w_start & (r_state == S_RUN);
            r_dout  <= w_proc ? w_bits : '0;
            r_ovf   <= w_proc ? w_ovf : '0;
            if (w_proc) begin
                r_mode <= w_mode;
                r_seen <= w_seen | din;
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= S_RUN;
                    r_cnt   <= w_idx + CW'(1);
                end
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_valid;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign ovf       = r_ovf;
    assign abort     = r_abort;
endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Bench for serial_twos_comp_n: word-level arithmetic model checked every cycle plus literal frame results.
module tb_serial_twos_comp_n;
    localparam int W  = 8;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] dout;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic [CH-1:0] ovf;
    logic          abort;

    int checks = 0;
    int failures = 0;

    serial_twos_comp_n #(.W(W), .CH(CH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
        .mode(mode), .din(din), .dout(dout), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last), .ovf(ovf), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame-level arithmetic on the bits received so far (bit i of -x depends only on x[i:0]).
    logic          exp_valid, exp_first, exp_last, exp_abort;
    logic [CH-1:0] exp_dout, exp_ovf;
    logic          m_open;
    int            m_idx;
    logic [1:0]    m_mode;
    logic [W-1:0]  m_acc [CH];

    initial begin
        logic [W-1:0] r;
        exp_valid = 0; exp_first = 0; exp_last = 0; exp_abort = 0;
        exp_dout = '0; exp_ovf = '0; m_open = 0; m_idx = 0; m_mode = 2'b00;
        forever begin
            @(posedge clk or negedge reset);
            exp_valid = 0; exp_first = 0; exp_last = 0; exp_abort = 0;
            exp_dout = '0; exp_ovf = '0;
            if (!reset) begin
                m_open = 0; m_idx = 0; m_mode = 2'b00;
            end else if (in_valid && (in_first || m_open)) begin
                if (in_first) begin
                    exp_abort = m_open;
                    m_mode = mode;
                    m_idx = 0;
                    for (int c = 0; c < CH; c++) m_acc[c] = '0;
                end
                for (int c = 0; c < CH; c++) begin
                    m_acc[c][m_idx] = din[c];
                    case (m_mode)
                        2'b01:   r = W'(0) - m_acc[c];
                        2'b10:   r = ~m_acc[c];
                        default: r = m_acc[c];
                    endcase
                    exp_dout[c] = r[m_idx];
                    exp_ovf[c] = (m_mode == 2'b01) && (m_idx == W-1) &&
                                 (m_acc[c] == (W'(1) << (W-1)));
                end
                exp_valid = 1;
                exp_first = (m_idx == 0);
                exp_last  = (m_idx == W-1);
                if (m_idx == W-1) begin
                    m_open = 0; m_idx = 0;
                end else begin
                    m_open = 1; m_idx++;
                end
            end
        end
    end

    // Cycle compare against the model, plus capture of completed output words.
    logic [CH-1:0][W-1:0] cap, done_word;
    logic [CH-1:0]        done_ovf;
    int cap_idx = 0, frames_done = 0, aborts = 0, gap = 0;
    logic cap_active = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, exp_valid);
            chk("out_first", out_first, exp_first);
            chk("out_last", out_last, exp_last);
            chk("abort", abort, exp_abort);
            if (exp_valid) begin
                chk("dout", dout, exp_dout);
                chk("ovf", ovf, exp_ovf);
            end
            if (abort) aborts++;
            if (out_valid) begin
                if (out_first) begin cap_idx = 0; cap_active = 1; end
                for (int c = 0; c < CH; c++) cap[c][cap_idx % W] = dout[c];
                cap_idx++;
                if (out_last) begin
                    done_word = cap; done_ovf = ovf; frames_done++; cap_active = 0;
                end
            end else if (cap_active) begin
                gap++;
            end
        end
    end

    task automatic beat(input logic f, input logic [1:0] m, input logic [CH-1:0][W-1:0] w, input int i);
        in_valid = 1; in_first = f;
        mode = f ? m : ~m;
        for (int c = 0; c < CH; c++) din[c] = w[c][i];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 0; in_first = 1'($urandom_range(1)); din = CH'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [CH-1:0][W-1:0] w, input logic [1:0] m,
                        input int stall_after, input int stall_len);
        for (int i = 0; i < W; i++) begin
            beat(i == 0, m, w, i);
            if (i == stall_after) idle(stall_len);
        end
        idle(2);
    endtask

    task automatic expect_words(input string tag, input logic [CH-1:0][W-1:0] e, input logic [CH-1:0] eo);
        for (int c = 0; c < CH; c++) chk($sformatf("%s_word%0d", tag, c), done_word[c], e[c]);
        chk({tag, "_ovf"}, done_ovf, eo);
    endtask

    initial begin
        logic [CH-1:0][W-1:0] w, e;
        int f0, a0;
        #12;
        chk("rst_dout", dout, 0); chk("rst_valid", out_valid, 0); chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0); chk("rst_ovf", ovf, 0); chk("rst_abort", abort, 0);
        @(negedge clk); reset = 1;

        w = '0; w[0] = 8'h0C; w[1] = 8'h33; w[2] = 8'hA5; w[3] = 8'h10;
        f0 = frames_done;
        send(w, 2'b01, -1, 0);
        $display("negate 0x0C -> %02h frames=%0d", done_word[0], frames_done - f0);
        chk("neg0C_word0", done_word[0], 8'hF4); chk("neg0C_ovf", done_ovf[0], 0);
        chk("neg0C_frames", frames_done - f0, 1);

        w[0] = 8'h80; w[1] = 8'h00; w[2] = 8'h01; w[3] = 8'h7F;
        send(w, 2'b01, -1, 0);
        e[0] = 8'h80; e[1] = 8'h00; e[2] = 8'hFF; e[3] = 8'h81;
        $display("negate quad -> %h ovf=%b", done_word, done_ovf);
        expect_words("negq", e, 4'b0001);

        send(w, 2'b10, -1, 0);
        e[0] = 8'h7F; e[1] = 8'hFF; e[2] = 8'hFE; e[3] = 8'h80;
        $display("ones quad -> %h ovf=%b", done_word, done_ovf);
        expect_words("oneq", e, 4'b0000);

        send(w, 2'b00, -1, 0);
        $display("pass quad -> %h", done_word);
        expect_words("passq", w, 4'b0000);

        send(w, 2'b11, -1, 0);
        $display("reserved quad -> %h", done_word);
        expect_words("rsvq", w, 4'b0000);

        // Stall of three idle cycles after bit 2.
        w[0] = 8'h0C;
        gap = 0;
        send(w, 2'b01, 2, 3);
        $display("stalled negate 0x0C -> %02h gap=%0d", done_word[0], gap);
        chk("stall_word0", done_word[0], 8'hF4); chk("stall_gap", gap, 3);

        // Abort: in_first at bit 5, new frame negates 0x01.
        f0 = frames_done; a0 = aborts;
        w[0] = 8'h55;
        for (int i = 0; i < 5; i++) beat(i == 0, 2'b10, w, i);
        w[0] = 8'h01;
        send(w, 2'b01, -1, 0);
        $display("abort then negate 0x01 -> %02h aborts=%0d frames=%0d", done_word[0], aborts - a0, frames_done - f0);
        chk("abort_count", aborts - a0, 1); chk("abort_frames", frames_done - f0, 1);
        chk("abort_word0", done_word[0], 8'hFF);

        // Reset asserted between edges in mid-frame.
        w[0] = 8'h0C;
        for (int i = 0; i < 4; i++) beat(i == 0, 2'b01, w, i);
        in_valid = 1; in_first = 0; din[0] = w[0][4];
        @(posedge clk); #2;
        chk("pre_rst_valid", out_valid, 1);
        reset = 0; #1;
        in_valid = 0;
        $display("mid-frame reset -> valid=%b dout=%b first=%b last=%b ovf=%b abort=%b",
                 out_valid, dout, out_first, out_last, ovf, abort);
        chk("mrst_dout", dout, 0); chk("mrst_valid", out_valid, 0); chk("mrst_first", out_first, 0);
        chk("mrst_last", out_last, 0); chk("mrst_ovf", ovf, 0); chk("mrst_abort", abort, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        f0 = frames_done;
        send(w, 2'b01, -1, 0);
        $display("post-reset negate 0x0C -> %02h", done_word[0]);
        chk("post_rst_word0", done_word[0], 8'hF4); chk("post_rst_frames", frames_done - f0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
